instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/program_counter.sv | 38 +++
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: address width, bubble encoding and fetch FSM states.
// HALT state exists only when FETCH_HALT_EN is defined.
package fetch_pkg;

  localparam int          ADDR_W   = 10;
  localparam logic [31:0] NOP_WORD = 32'h41E00000;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } fetch_state_t;
`endif

endpackage

// File: rtl/program_counter.sv
// PC register with next-PC mux (load > advance > hold); modulo 2^ADDR_W increment.
// Latency: one edge from load/advance to pc; hold when neither is asserted.
module program_counter #(
  parameter int ADDR_W = fetch_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_nxt;

  assign pc_plus1 = pc + ONE;

  always_comb begin
    pc_nxt = pc;
    if (load) begin
      pc_nxt = target;
    end else if (advance) begin
      pc_nxt = pc_plus1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC drives memory, IF/ID captures word; 1 edge per fetch, IDLE one cycle after reset.
// Stall holds PC and IF/ID, branch redirects and bubbles; optional halt at END_ADDR with FETCH_HALT_EN.
module instruction_fetch #(
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter logic [31:0]       NOP_WORD = fetch_pkg::NOP_WORD,
  parameter logic [ADDR_W-1:0] END_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              Clk,
  input  logic              Reset_n,
  output logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Instruction,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic [31:0]       IfId_Instr,
  output logic [ADDR_W-1:0] IfId_PC,
  output logic              IfId_Valid
`ifdef FETCH_HALT_EN
  ,
  output logic              Halted
`endif
);

  import fetch_pkg::*;

  fetch_state_t      state, state_nxt;
  logic              pc_load, pc_adv;
  logic              capture, bubble;
  logic [ADDR_W-1:0] pc, pc_plus1;

  program_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (pc_load),
    .advance  (pc_adv),
    .target   (BranchTarget),
    .pc       (pc),
    .pc_plus1 (pc_plus1)
  );

  assign Addr = pc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_adv    = 1'b0;
    capture   = 1'b0;
    bubble    = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN: begin
        if (BranchTaken) begin
          pc_load = 1'b1;
          bubble  = 1'b1;
        end else if (!Stall) begin
          capture = 1'b1;
`ifdef FETCH_HALT_EN
          // The final instruction is still delivered; PC parks on END_ADDR.
          if (pc == END_ADDR) begin
            state_nxt = ST_HALT;
          end else begin
            pc_adv = 1'b1;
          end
`else
          pc_adv = 1'b1;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALT: bubble = 1'b1;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      IfId_Instr <= NOP_WORD;
      IfId_PC    <= '0;
      IfId_Valid <= 1'b0;
    end else if (bubble) begin
      IfId_Instr <= NOP_WORD;
      IfId_Valid <= 1'b0;
    end else if (capture) begin
      IfId_Instr <= Instruction;
      IfId_PC    <= pc_plus1;
      IfId_Valid <= 1'b1;
    end
  end

`ifdef FETCH_HALT_EN
  assign Halted = (state == ST_HALT);
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch against a spec-level fetch model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h41E00000;
`ifdef FETCH_HALT_EN
  localparam int          HALT_EN = 1;
  localparam logic [9:0]  END_A   = 10'd25;
`else
  localparam int          HALT_EN = 0;
  localparam logic [9:0]  END_A   = 10'd1023;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  Addr;
  logic [31:0] Instruction;
  logic        Stall;
  logic        BranchTaken;
  logic [9:0]  BranchTarget;
  logic [31:0] IfId_Instr;
  logic [9:0]  IfId_PC;
  logic        IfId_Valid;
  logic        Halted;

  logic [31:0] mem [1024];
  assign Instruction = mem[Addr];

  always #5 Clk = ~Clk;

  instruction_fetch #(.ADDR_W(10), .NOP_WORD(NOP), .END_ADDR(END_A)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Addr         (Addr),
    .Instruction  (Instruction),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .IfId_Instr   (IfId_Instr),
    .IfId_PC      (IfId_PC),
    .IfId_Valid   (IfId_Valid)
`ifdef FETCH_HALT_EN
    ,
    .Halted       (Halted)
`endif
  );
`ifndef FETCH_HALT_EN
  assign Halted = 1'b0;
`endif

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] instr;
    logic [9:0]  ifpc;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: started=0 means the post-reset idle edge is still to come.
  int          m_pc;
  logic [31:0] m_instr;
  int          m_ifpc;
  logic        m_valid;
  bit          m_started;
  bit          m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = NOP; m_ifpc = 0; m_valid = 1'b0;
    m_started = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_step(input logic br, input logic [9:0] tgt, input logic st);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_halted) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (br) begin
      m_pc = int'(tgt); m_instr = NOP; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = mem[m_pc];
      m_ifpc  = (m_pc + 1) % 1024;
      m_valid = 1'b1;
      if (HALT_EN != 0 && m_pc == int'(END_A)) m_halted = 1'b1;
      else m_pc = (m_pc + 1) % 1024;
    end
  endtask

  task automatic cycle(input logic br, input logic [9:0] tgt, input logic st);
    exp_t e;
    @(negedge Clk);
    BranchTaken = br; BranchTarget = tgt; Stall = st;
    model_step(br, tgt, st);
    e.addr = 10'(m_pc); e.instr = m_instr; e.ifpc = 10'(m_ifpc);
    e.valid = m_valid; e.halted = m_halted;
    q.push_back(e);
  endtask

  task automatic release_reset();
    @(posedge Clk);
    #2 Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"},  32'(Addr), 32'd0);
    chk({tag, "_instr"}, IfId_Instr, NOP);
    chk({tag, "_ifpc"},  32'(IfId_PC), 32'd0);
    chk({tag, "_valid"}, 32'(IfId_Valid), 32'd0);
    chk({tag, "_halted"}, 32'(Halted), 32'd0);
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("addr",  32'(Addr), 32'(e.addr));
        chk("instr", IfId_Instr, e.instr);
        chk("ifpc",  32'(IfId_PC), 32'(e.ifpc));
        chk("valid", 32'(IfId_Valid), 32'(e.valid));
        chk("halted", 32'(Halted), 32'(e.halted));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = NOP;
    Reset_n = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 check_reset_values("rst");

    // Reset release and first fetches, then stall three cycles at PC=5
    release_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 10'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'd0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'd0, 1'b0);

    // Branch during stall, then wrap through 1023
    cycle(1'b1, 10'd16, 1'b1);
    cycle(1'b0, 10'd0, 1'b0);
    cycle(1'b0, 10'd0, 1'b0);
    cycle(1'b1, 10'd1023, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'd0, 1'b0);

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 7) == 0), 10'($urandom), ($urandom_range(0, 3) == 0));

    // Asynchronous reset while a branch and stall are being requested
    @(negedge Clk);
    BranchTaken = 1'b1; BranchTarget = 10'd100; Stall = 1'b1;
    #2 Reset_n = 1'b0;
    #1 check_reset_values("async");
    BranchTaken = 1'b0; Stall = 1'b0;
    repeat (2) @(posedge Clk);
    release_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 10'd0, 1'b0);

    // Halt at END_ADDR; later branches and stalls have no effect
    cycle(1'b1, 10'd20, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 10'd0, ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 6; i++) cycle(1'b0, 10'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 10'd3, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 10'd7, 1'b0);

    repeat (3) @(posedge Clk);
    #2 chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
